// File: rtl/wiredpanda_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wiredpanda_io_pkg
// Brief    : Shared types and constants for the push-button conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package wiredpanda_io_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } chan_state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int PRESS_COUNT_WIDTH       = 8;

  // Width of the stability counter. It holds values up to cycles-1 and is
  // never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage : wiredpanda_io_pkg
`default_nettype wire

// File: rtl/wiredpanda_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : wiredpanda_debounce_channel
// Brief    : One push-button channel: 2-flop synchronizer, debounce FSM with
//            stability counter, registered level and press/release pulses.
// Revision : 1.0 - initial release
// ============================================================================
module wiredpanda_debounce_channel
  import wiredpanda_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_event    // high in the cycle before press_pulse
);

  localparam int               CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync2_q;
  chan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;

  // Synchronizer and debounce state registers; reset drops everything to idle-low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= STABLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= button_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive opposite-level samples; any interruption returns to stable.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (sync2_q) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHECK_HIGH: begin
        if (!sync2_q) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!sync2_q) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHECK_LOW: begin
        if (sync2_q) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE_LOW;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == STABLE_HIGH) || (state_d == CHECK_LOW);
  end

  assign button_level  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_event   = press_d;

endmodule : wiredpanda_debounce_channel
`default_nettype wire

// File: rtl/wiredpanda_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : wiredpanda_button_conditioner
// Brief    : NUM_BUTTONS debounced push-button channels plus a shared
//            modulo-256 count of accepted presses.
// Revision : 1.0 - initial release
// ============================================================================
module wiredpanda_button_conditioner
  import wiredpanda_io_pkg::*;
#(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_BUTTONS-1:0]       button_raw,
  input  logic                         count_clr,
  output logic [NUM_BUTTONS-1:0]       button_level,
  output logic [NUM_BUTTONS-1:0]       press_pulse,
  output logic [NUM_BUTTONS-1:0]       release_pulse,
  output logic [PRESS_COUNT_WIDTH-1:0] press_count
);

  logic [NUM_BUTTONS-1:0]       press_event;
  logic [PRESS_COUNT_WIDTH-1:0] press_add;
  logic [PRESS_COUNT_WIDTH-1:0] count_q, count_d;

  generate
    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_channel
      wiredpanda_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_channel (
        .clk           (clk),
        .reset         (reset),
        .button_raw    (button_raw[g]),
        .button_level  (button_level[g]),
        .press_pulse   (press_pulse[g]),
        .release_pulse (release_pulse[g]),
        .press_event   (press_event[g])
      );
    end
  endgenerate

  // Count presses from the channels' next-pulse signals so the count
  // updates on the same edge the press pulses appear; clear wins.
  always_comb begin
    press_add = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      press_add = press_add + {{(PRESS_COUNT_WIDTH-1){1'b0}}, press_event[i]};
    end
    count_d = count_clr ? '0 : (count_q + press_add);
  end

  // Press counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign press_count = count_q;

endmodule : wiredpanda_button_conditioner
`default_nettype wire

// File: tb/tb_wiredpanda_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_wiredpanda_button_conditioner
// Brief    : Self-checking bench: run-length behavioural model checked every
//            cycle plus directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wiredpanda_button_conditioner;

  localparam int NB = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] button_raw = '0;
  logic          count_clr = 1'b0;
  logic [NB-1:0] button_level, press_pulse, release_pulse;
  logic [7:0]    press_count;

  int n_checks = 0;
  int n_fail   = 0;

  wiredpanda_button_conditioner #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button_raw    (button_raw),
    .count_clr     (count_clr),
    .button_level  (button_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  // Model: two-sample delay line, then a level flips once the delayed input
  // has disagreed with it for DC consecutive samples.
  logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  int            m_run [NB];
  logic [7:0]    m_count;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_count = '0;
      for (int c = 0; c < NB; c++) m_run[c] = 0;
    end else begin
      int np;
      np = 0;
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < NB; c++) begin
        if (m_s2[c] != m_level[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DC) begin
            m_level[c] = m_s2[c];
            if (m_s2[c]) begin m_press[c] = 1'b1; np = np + 1; end
            else         m_rel[c] = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      if (count_clr) m_count = 8'd0;
      else           m_count = 8'((int'(m_count) + np) % 256);
      m_s2 = m_s1;
      m_s1 = button_raw;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("model_level",   int'(button_level),  int'(m_level));
    chk("model_press",   int'(press_pulse),   int'(m_press));
    chk("model_release", int'(release_pulse), int'(m_rel));
    chk("model_count",   int'(press_count),   int'(m_count));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_level", int'(button_level), 0);
    chk("reset_count", int'(press_count), 0);
    reset = 1'b0;
    tick(2);

    // Clean press on channel 0.
    button_raw[0] = 1'b1;
    tick(5);
    chk("press0_before", int'(button_level[0]), 0);
    tick(1);
    chk("press0_level", int'(button_level[0]), 1);
    chk("press0_pulse", int'(press_pulse[0]), 1);
    chk("press0_count", int'(press_count), 1);
    tick(1);
    chk("press0_pulse_end", int'(press_pulse[0]), 0);

    // Bounce on channel 1: high 3, low 1, then held.
    button_raw[1] = 1'b1; tick(3);
    button_raw[1] = 1'b0; tick(1);
    button_raw[1] = 1'b1; tick(5);
    chk("bounce_before", int'(button_level[1]), 0);
    tick(1);
    chk("bounce_level", int'(button_level[1]), 1);
    chk("bounce_pulse", int'(press_pulse[1]), 1);
    chk("bounce_count", int'(press_count), 2);

    // Release on channel 0.
    button_raw[0] = 1'b0;
    tick(5);
    chk("release_before", int'(button_level[0]), 1);
    tick(1);
    chk("release_pulse", int'(release_pulse[0]), 1);
    chk("release_level", int'(button_level[0]), 0);
    chk("release_count", int'(press_count), 2);

    // Release channel 1, then bring the count to 255 with channel 0 presses.
    button_raw[1] = 1'b0; tick(8);
    for (int k = 0; k < 253; k++) begin
      button_raw[0] = 1'b1; tick(7);
      button_raw[0] = 1'b0; tick(7);
    end
    chk("count_255", int'(press_count), 255);

    // Simultaneous presses wrap the count: 255 + 2 -> 1.
    button_raw = 2'b11;
    tick(6);
    chk("simul_pulses", int'(press_pulse), 3);
    chk("simul_wrap", int'(press_count), 1);

    // Simultaneous presses together with a clear: clear wins.
    button_raw = 2'b00; tick(8);
    button_raw = 2'b11; tick(5);
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    chk("clr_pulses", int'(press_pulse), 3);
    chk("clr_count", int'(press_count), 0);

    // Reset in the middle of a press.
    button_raw = 2'b00; tick(8);
    button_raw[0] = 1'b1;
    tick(2);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_level", int'(button_level), 0);
    chk("rst_mid_pulses", int'(press_pulse | release_pulse), 0);
    chk("rst_mid_count", int'(press_count), 0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("rst_rearm_before", int'(button_level[0]), 0);
    tick(1);
    chk("rst_rearm_level", int'(button_level[0]), 1);
    chk("rst_rearm_pulse", int'(press_pulse[0]), 1);
    chk("rst_rearm_count", int'(press_count), 1);
    tick(3);
    chk("rst_rearm_once", int'(press_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wiredpanda_button_conditioner
`default_nettype wire
